// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over N_REQ request lines with a registered binary grant index
// delivered over a valid/ready handshake. The winner becomes lowest priority on the
// next arbitration.
// Optional feature: define ARB_LOCK_EN to add the lock input, which holds the pointer
// across handshakes so one requester can own several consecutive beats.
module rr_index_arbiter #(
  parameter int unsigned N_REQ = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  input  logic             grant_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic             lock
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;

  logic             handshake_c;
  logic             lock_c;
  logic             hold_c;
  logic [IDX_W-1:0] next_ptr_c;
  logic [IDX_W-1:0] base_ptr_c;
  logic             found_c;
  logic [IDX_W-1:0] win_c;

`ifdef ARB_LOCK_EN
  assign lock_c = lock;
`else
  assign lock_c = 1'b0;
`endif

  assign handshake_c = grant_valid & grant_ready;

  // Pointer after a handshake; a locked handshake leaves it where it is.
  always_comb begin
    next_ptr_c = ptr;
    if (!lock_c) begin
      next_ptr_c = grant_idx + IDX_W'(1);
    end
  end

  // Re-arbitration on a handshake uses the updated pointer, so back-to-back grants need no bubble.
  always_comb begin
    base_ptr_c = ptr;
    if (handshake_c) begin
      base_ptr_c = next_ptr_c;
    end
  end

  // Locked owner keeps the grant while its request is still asserted.
  assign hold_c = handshake_c & lock_c & req[grant_idx];

  // Circular first-set search starting at base_ptr_c.
  always_comb begin
    logic [IDX_W-1:0] idx;
    found_c = 1'b0;
    win_c   = base_ptr_c;
    idx     = base_ptr_c;
    for (int i = 0; i < N_REQ; i++) begin
      idx = base_ptr_c + IDX_W'(i);
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        win_c   = idx;
      end
    end
    if (hold_c) begin
      found_c = 1'b1;
      win_c   = grant_idx;
    end
  end

  // Grant FSM: state, pointer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            grant_idx   <= win_c;
            grant_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            ptr <= next_ptr_c;
            if (found_c) begin
              grant_idx <= win_c;
            end else begin
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter: reset, full rotation with wrap, stall stability,
// request drop while stalled, async reset mid-offer and, when ARB_LOCK_EN is defined, lock.
module tb_rr_index_arbiter;

  localparam int unsigned N_REQ = 32;
  localparam int unsigned IDX_W = 5;

  logic             clk;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             grant_ready;
`ifdef ARB_LOCK_EN
  logic             lock;
`endif

  int checks;
  int errors;

  rr_index_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready)
`ifdef ARB_LOCK_EN
    ,
    .lock        (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    req         = 32'hFFFF_FFFF;
    grant_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock        = 1'b0;
`endif

    // Reset holds outputs at zero even with all requests asserted.
    step();
    step();
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    rst = 1'b0;

    // First grant one cycle after release, from ptr 0.
    step();
    check("first_valid", 32'(grant_valid), 32'd1);
    check("first_idx", 32'(grant_idx), 32'd0);

    // Full rotation with ready held high, wrapping 31 -> 0.
    grant_ready = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      check($sformatf("rot_idx_%0d", k), 32'(grant_idx), 32'(k % 32));
      check($sformatf("rot_valid_%0d", k), 32'(grant_valid), 32'd1);
    end

    // Accept with no requests left -> back to IDLE, ptr = 1.
    req = '0;
    step();
    check("drain_valid", 32'(grant_valid), 32'd0);

    // Stall on index 2 for five cycles, then accept -> 8.
    grant_ready = 1'b0;
    req         = 32'h0000_0104;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall_idx_%0d", k), 32'(grant_idx), 32'd2);
      check($sformatf("stall_valid_%0d", k), 32'(grant_valid), 32'd1);
    end
    grant_ready = 1'b1;
    step();
    check("after_stall_idx", 32'(grant_idx), 32'd8);
    check("after_stall_valid", 32'(grant_valid), 32'd1);

    // Accept 8 -> search from 9 wraps round to 2.
    step();
    check("wrap_to_2_idx", 32'(grant_idx), 32'd2);

    // Drop req[2] while stalled; the grant is never withdrawn.
    grant_ready = 1'b0;
    req         = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("drop_idx_%0d", k), 32'(grant_idx), 32'd2);
      check($sformatf("drop_valid_%0d", k), 32'(grant_valid), 32'd1);
    end
    grant_ready = 1'b1;
    step();
    check("drop_accept_valid", 32'(grant_valid), 32'd0);

    // Ready while idle is ignored.
    step();
    check("idle_ready_valid", 32'(grant_valid), 32'd0);

    // Pointer advanced to 3 after accepting index 2.
    grant_ready = 1'b0;
    req         = 32'hFFFF_FFFF;
    step();
    check("ptr3_idx", 32'(grant_idx), 32'd3);
    check("ptr3_valid", 32'(grant_valid), 32'd1);

    // Short async reset pulse mid-offer drops the grant immediately.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(grant_valid), 32'd0);
    check("async_rst_idx", 32'(grant_idx), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_idx", 32'(grant_idx), 32'd0);
    check("post_rst_valid", 32'(grant_valid), 32'd1);

    // Single high requester beyond the pointer.
    grant_ready = 1'b1;
    req         = 32'h8000_0000;
    step();
    check("bit31_idx", 32'(grant_idx), 32'd31);
    req = 32'h8000_0001;
    step();
    check("wrap_0_idx", 32'(grant_idx), 32'd0);

`ifdef ARB_LOCK_EN
    // Lock keeps index 0 across handshakes; releasing it moves on to 4.
    req  = 32'h0000_0011;
    lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("lock_idx_%0d", k), 32'(grant_idx), 32'd0);
    end
    lock = 1'b0;
    step();
    check("unlock_idx", 32'(grant_idx), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
